// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - ID decode plus EX/MEM/WB control pipeline with load-use stall, flush and bubble counter
// Optional I-type decode and flush bubble accounting: define CTRL_IMM_EN.
module ctrl_pipeline #(
    parameter int ALU_OP_W = 2,
    parameter int RA_W     = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [6:0]          id_opcode,
    input  logic [RA_W-1:0]     id_rs1,
    input  logic [RA_W-1:0]     id_rs2,
    input  logic [RA_W-1:0]     id_rd,
    input  logic                flush,
    output logic                hazard_stall,
    output logic                id_illegal,
    output logic                ex_valid,
    output logic                ex_alu_src,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [RA_W-1:0]     ex_rd,
    output logic                mem_valid,
    output logic                mem_branch,
    output logic                mem_read,
    output logic                mem_write,
    output logic [RA_W-1:0]     mem_rd,
    output logic                wb_valid,
    output logic                wb_mem_to_reg,
    output logic                wb_reg_write,
    output logic [RA_W-1:0]     wb_rd,
    output logic [CNT_W-1:0]    bubble_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef CTRL_IMM_EN
    localparam logic [6:0] OP_IMM    = 7'b0010011;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic                valid;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
        logic                branch;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                reg_write;
        logic [RA_W-1:0]     rd;
    } ex_t;

    typedef struct packed {
        logic                valid;
        logic                branch;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                reg_write;
        logic [RA_W-1:0]     rd;
    } mem_t;

    typedef struct packed {
        logic                valid;
        logic                mem_to_reg;
        logic                reg_write;
        logic [RA_W-1:0]     rd;
    } wb_t;

    ex_t  dec;
    ex_t  ex_q;
    mem_t mem_q;
    wb_t  wb_q;
    logic known;
    logic rs1_used;
    logic rs2_used;

    always_comb begin
        dec      = '0;
        known    = 1'b1;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (id_opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_OP_W'(2);
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                rs1_used       = 1'b1;
            end
            OP_STORE: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
            end
            OP_BRANCH: begin
                dec.alu_op = ALU_OP_W'(1);
                dec.branch = 1'b1;
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
            end
`ifdef CTRL_IMM_EN
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_OP_W'(3);
                rs1_used      = 1'b1;
            end
`endif
            default: known = 1'b0;
        endcase
        // Invalid or undecodable instructions enter EX as a clean bubble.
        if (!id_valid || !known) begin
            dec      = '0;
            rs1_used = 1'b0;
            rs2_used = 1'b0;
        end else begin
            dec.valid = 1'b1;
            dec.rd    = id_rd;
        end
    end

    assign id_illegal   = rst_n & id_valid & ~known;
    assign hazard_stall = rst_n & ~flush & id_valid & ex_q.valid & ex_q.mem_read &
                          (ex_q.rd != '0) &
                          ((rs1_used & (ex_q.rd == id_rs1)) | (rs2_used & (ex_q.rd == id_rs2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q <= '{valid: mem_q.valid, mem_to_reg: mem_q.mem_to_reg,
                      reg_write: mem_q.reg_write, rd: mem_q.rd};
            if (flush) begin
                ex_q  <= '0;
                mem_q <= '0;
            end else begin
                mem_q <= '{valid: ex_q.valid, branch: ex_q.branch, mem_read: ex_q.mem_read,
                           mem_write: ex_q.mem_write, mem_to_reg: ex_q.mem_to_reg,
                           reg_write: ex_q.reg_write, rd: ex_q.rd};
                ex_q  <= hazard_stall ? '0 : dec;
            end
        end
    end

    // Stall and flush are mutually exclusive because flush masks hazard_stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (hazard_stall) begin
            if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + CNT_W'(1);
`ifdef CTRL_IMM_EN
        end else if (flush) begin
            bubble_cnt <= (bubble_cnt >= CNT_MAX - CNT_W'(1)) ? CNT_MAX : bubble_cnt + CNT_W'(2);
`endif
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_rd         = ex_q.rd;
    assign mem_valid     = mem_q.valid;
    assign mem_branch    = mem_q.branch;
    assign mem_read      = mem_q.mem_read;
    assign mem_write     = mem_q.mem_write;
    assign mem_rd        = mem_q.rd;
    assign wb_valid      = wb_q.valid;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_rd         = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - scoreboard bench for ctrl_pipeline with a 2-bit bubble counter
module tb_ctrl_pipeline;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;
`ifdef CTRL_IMM_EN
    localparam bit IMM = 1'b1;
`else
    localparam bit IMM = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       flush;
    logic       hazard_stall, id_illegal;
    logic       ex_valid, ex_alu_src;
    logic [1:0] ex_alu_op;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_branch, mem_read, mem_write;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_mem_to_reg, wb_reg_write;
    logic [4:0] wb_rd;
    logic [1:0] bubble_cnt;

    ctrl_pipeline #(.ALU_OP_W(2), .RA_W(5), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .hazard_stall(hazard_stall), .id_illegal(id_illegal),
        .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_branch(mem_branch), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .bubble_cnt(bubble_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;
    logic [7:0] mem_exp_q[$];
    logic [6:0] wb_exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Expected MEM {branch,read,write,rd} and WB {mem_to_reg,reg_write,rd} per opcode.
    task automatic push_exp(input logic [6:0] op, input logic [4:0] rd);
        case (op)
            OP_R:      begin mem_exp_q.push_back({3'b000, rd}); wb_exp_q.push_back({2'b01, rd}); end
            OP_LOAD:   begin mem_exp_q.push_back({3'b010, rd}); wb_exp_q.push_back({2'b11, rd}); end
            OP_STORE:  begin mem_exp_q.push_back({3'b001, rd}); wb_exp_q.push_back({2'b00, rd}); end
            OP_BRANCH: begin mem_exp_q.push_back({3'b100, rd}); wb_exp_q.push_back({2'b00, rd}); end
            default:   begin mem_exp_q.push_back({3'b000, rd}); wb_exp_q.push_back({2'b01, rd}); end
        endcase
    endtask

    task automatic issue(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input bit push);
        id_valid  = 1'b1;
        id_opcode = op;
        id_rs1    = r1;
        id_rs2    = r2;
        id_rd     = rd;
        if (push) push_exp(op, rd);
        settle();
    endtask

    task automatic idle();
        id_valid  = 1'b0;
        id_opcode = 7'd0;
        id_rs1    = 5'd0;
        id_rs2    = 5'd0;
        id_rd     = 5'd0;
        settle();
    endtask

    function automatic int sat(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_valid) begin
                if (mem_exp_q.size() == 0) chk("mem_unexpected", {mem_branch, mem_read, mem_write, mem_rd}, 32'hdead);
                else chk("mem_ctrl", {mem_branch, mem_read, mem_write, mem_rd}, mem_exp_q.pop_front());
            end
            if (wb_valid) begin
                if (wb_exp_q.size() == 0) chk("wb_unexpected", {wb_mem_to_reg, wb_reg_write, wb_rd}, 32'hdead);
                else chk("wb_ctrl", {wb_mem_to_reg, wb_reg_write, wb_rd}, wb_exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        id_valid = 1'b1; id_opcode = OP_BAD; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        tick(); tick();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_cnt", bubble_cnt, 0);
        chk("rst_illegal", id_illegal, 0);
        idle();
        rst_n = 1'b1;

        // R then store back-to-back
        issue(OP_R, 5'd1, 5'd2, 5'd5, 1);
        chk("s1_hz0", hazard_stall, 0);
        tick();
        issue(OP_STORE, 5'd1, 5'd5, 5'd6, 1);
        chk("s1_ex_alu_op", ex_alu_op, 2'b10);
        chk("s1_ex_valid", ex_valid, 1);
        chk("s1_hz1", hazard_stall, 0);
        tick();
        idle();
        chk("s1_ex_store_src", ex_alu_src, 1);
        chk("s1_hz2", hazard_stall, 0);
        tick();
        chk("s1_wb_reg_write", wb_reg_write, 1);
        chk("s1_wb_rd", wb_rd, 5);
        chk("s1_mem_write", mem_write, 1);
        tick(); tick();

        // load x0 then R using x0: no hazard
        issue(OP_LOAD, 5'd1, 5'd0, 5'd0, 1);
        tick();
        issue(OP_R, 5'd0, 5'd2, 5'd8, 1);
        chk("s3_hz", hazard_stall, 0);
        tick();
        idle();
        chk("s3_cnt", bubble_cnt, 0);
        tick(); tick(); tick();

        // load x7 then R with rs2=7: one-cycle stall
        issue(OP_LOAD, 5'd1, 5'd0, 5'd7, 1);
        tick();
        issue(OP_R, 5'd1, 5'd7, 5'd8, 1);
        chk("s2_hz_on", hazard_stall, 1);
        tick();
        exp_cnt = 1;
        issue(OP_R, 5'd1, 5'd7, 5'd8, 0);
        chk("s2_hz_off", hazard_stall, 0);
        chk("s2_ex_bubble", ex_valid, 0);
        chk("s2_cnt", bubble_cnt, exp_cnt);
        tick();
        idle();
        tick(); tick();
        chk("s2_wb_valid_c5", wb_valid, 1);
        chk("s2_wb_rd_c5", wb_rd, 8);
        tick(); tick();

        // flush overrides a pending load-use stall
        issue(OP_R, 5'd1, 5'd2, 5'd9, 1);
        tick();
        issue(OP_LOAD, 5'd2, 5'd0, 5'd3, 0);
        tick();
        issue(OP_R, 5'd3, 5'd4, 5'd10, 0);
        flush = 1'b1;
        settle();
        chk("fl_hz_masked", hazard_stall, 0);
        tick();
        flush = 1'b0;
        idle();
        exp_cnt = IMM ? sat(exp_cnt + 2) : exp_cnt;
        chk("fl_ex_bubble", ex_valid, 0);
        chk("fl_mem_bubble", mem_valid, 0);
        chk("fl_wb_valid", wb_valid, 1);
        chk("fl_wb_rd", wb_rd, 9);
        chk("fl_cnt", bubble_cnt, exp_cnt);
        tick(); tick();

        // branch, I-type opcode and an undecodable opcode
        issue(OP_BRANCH, 5'd1, 5'd2, 5'd0, 1);
        chk("br_illegal", id_illegal, 0);
        tick();
        issue(OP_IMM, 5'd1, 5'd0, 5'd4, IMM);
        chk("imm_illegal", id_illegal, IMM ? 0 : 1);
        chk("br_ex_alu_op", ex_alu_op, 2'b01);
        tick();
        issue(OP_BAD, 5'd1, 5'd2, 5'd3, 0);
        chk("imm_ex_valid", ex_valid, IMM ? 1 : 0);
        chk("imm_ex_alu_src", ex_alu_src, IMM ? 1 : 0);
        chk("imm_ex_alu_op", ex_alu_op, IMM ? 3 : 0);
        chk("bad_illegal", id_illegal, 1);
        tick();
        id_valid = 1'b0;
        settle();
        chk("bad_ex_bubble", ex_valid, 0);
        chk("bad_ex_rd", ex_rd, 0);
        chk("inv_illegal", id_illegal, 0);
        idle();
        tick(); tick(); tick();

        // repeated stalls saturate the 2-bit counter
        for (int i = 0; i < 4; i++) begin
            issue(OP_LOAD, 5'd1, 5'd0, 5'd7, 1);
            tick();
            issue(OP_R, 5'd1, 5'd7, 5'd8, 1);
            chk("sat_hz", hazard_stall, 1);
            tick();
            exp_cnt = sat(exp_cnt + 1);
            chk("sat_cnt", bubble_cnt, exp_cnt);
            issue(OP_R, 5'd1, 5'd7, 5'd8, 0);
            tick();
        end
        idle();
        tick(); tick(); tick();

        // asynchronous reset in the middle of traffic
        issue(OP_R, 5'd1, 5'd2, 5'd11, 1);
        tick();
        issue(OP_LOAD, 5'd1, 5'd0, 5'd12, 1);
        tick();
        issue(OP_R, 5'd1, 5'd12, 5'd13, 1);
        chk("mr_hz_before", hazard_stall, 1);
        rst_n = 1'b0;
        mem_exp_q.delete();
        wb_exp_q.delete();
        #1;
        chk("mr_hz", hazard_stall, 0);
        chk("mr_ex", {ex_valid, ex_alu_src, ex_alu_op, ex_rd}, 0);
        chk("mr_mem", {mem_valid, mem_branch, mem_read, mem_write, mem_rd}, 0);
        chk("mr_wb", {wb_valid, wb_mem_to_reg, wb_reg_write, wb_rd}, 0);
        chk("mr_cnt", bubble_cnt, 0);
        id_opcode = OP_BAD;
        settle();
        chk("mr_illegal", id_illegal, 0);
        idle();
        tick();
        rst_n = 1'b1;
        issue(OP_R, 5'd1, 5'd2, 5'd14, 1);
        tick();
        idle();
        chk("post_rst_ex_rd", ex_rd, 14);
        tick(); tick(); tick();
        chk("mem_q_drained", mem_exp_q.size(), 0);
        chk("wb_q_drained", wb_exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
